// File: rtl/fp_unit_arbiter.sv
// fp_unit_arbiter
//
// Shares one double-precision arithmetic core (multiplier, adder or divider)
// between N requesters. Requesters are served one at a time in round-robin
// order. The winning operands are registered toward the core, followed by a
// one-cycle start pulse. The core's result is returned with a one-cycle
// one-hot acknowledge. If the core never signals completion, a watchdog
// resets it and returns a quiet NaN with an error flag.
//
// Ports:
//   clk             - system clock, rising edge
//   reset           - synchronous active-low reset
//   req[N]          - level requests, held with operands until ack
//   dataa_in/datab_in[64*N] - operand pairs, requester i at [64i+63:64i]
//   ack[N]          - one-hot completion pulse for the granted requester
//   err             - pulses with ack when the operation timed out
//   result[64]      - registered result, held until the next ack
//   busy            - high whenever the sequencer is not idle
//   unit_reset      - active-high reset to the shared core
//   unit_in_ready   - one-cycle start pulse to the core
//   unit_dataa/b    - registered operands to the core
//   unit_result     - core result
//   unit_data_ready - core completion pulse
module fp_unit_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [64*N-1:0] dataa_in,
  input  logic [64*N-1:0] datab_in,
  output logic [N-1:0]    ack,
  output logic            err,
  output logic [63:0]     result,
  output logic            busy,
  output logic            unit_reset,
  output logic            unit_in_ready,
  output logic [63:0]     unit_dataa,
  output logic [63:0]     unit_datab,
  input  logic [63:0]     unit_result,
  input  logic            unit_data_ready
);

  localparam int IW = $clog2(N);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [63:0]   QNAN     = 64'h7FF8_0000_0000_0000;
  localparam logic [IW-1:0] PTR_RST  = IW'(N - 1);
  localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [WW-1:0] wd_q, wd_d;
  logic          err_flag_q, err_flag_d;
  logic          unit_reset_q, unit_reset_d;
  logic [63:0]   result_q, result_d;
  logic [63:0]   dataa_q, dataa_d;
  logic [63:0]   datab_q, datab_d;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic [IW:0]   cand;
  logic [63:0]   pick_a, pick_b;

  // Round-robin search starting just after the last served requester.
  // Offsets are scanned from farthest to nearest so the nearest hit wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = N; i >= 1; i--) begin
      cand = {1'b0, ptr_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      if (req[cand[IW-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    pick_a = '0;
    pick_b = '0;
    for (int j = 0; j < N; j++) begin
      if (pick_idx == IW'(j)) begin
        pick_a = dataa_in[64*j +: 64];
        pick_b = datab_in[64*j +: 64];
      end
    end
  end

  // Next-state logic. A completion pulse in the timeout cycle takes priority
  // over the watchdog, so a late-but-valid result is never discarded.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    grant_d      = grant_q;
    wd_d         = wd_q;
    err_flag_d   = err_flag_q;
    unit_reset_d = 1'b0;
    result_d     = result_q;
    dataa_d      = dataa_q;
    datab_d      = datab_q;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          dataa_d = pick_a;
          datab_d = pick_b;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wd_d       = '0;
        err_flag_d = 1'b0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (unit_data_ready) begin
          result_d = unit_result;
          state_d  = DONE;
        end else if (wd_q == WD_LIMIT) begin
          result_d     = QNAN;
          err_flag_d   = 1'b1;
          unit_reset_d = 1'b1;
          state_d      = DONE;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      DONE: begin
        ptr_d   = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      ptr_q        <= PTR_RST;
      grant_q      <= '0;
      wd_q         <= '0;
      err_flag_q   <= 1'b0;
      unit_reset_q <= 1'b0;
      result_q     <= '0;
      dataa_q      <= '0;
      datab_q      <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      grant_q      <= grant_d;
      wd_q         <= wd_d;
      err_flag_q   <= err_flag_d;
      unit_reset_q <= unit_reset_d;
      result_q     <= result_d;
      dataa_q      <= dataa_d;
      datab_q      <= datab_d;
    end
  end

  always_comb begin
    ack = '0;
    for (int j = 0; j < N; j++) begin
      ack[j] = (state_q == DONE) && (grant_q == IW'(j));
    end
  end

  // The core is held in reset for as long as the arbiter is, so a reset in
  // the middle of an operation also discards the core's pending work.
  assign unit_reset    = ~reset | unit_reset_q;
  assign err           = (state_q == DONE) & err_flag_q;
  assign busy          = (state_q != IDLE);
  assign unit_in_ready = (state_q == ISSUE);
  assign result        = result_q;
  assign unit_dataa    = dataa_q;
  assign unit_datab    = datab_q;

endmodule
